vga_sync_gen: RTL and testbench

- Source of the ipixel_x/ipixel_y coordinate stream that the draw_* object generators consume, plus the horizontal and vertical sync signals for the VGA connector.
- Generates standard 640x480@60 timing from the board clock through a pixel-tick divider.
- Supplies video_on, so the top-level RGB mux blanks outside the visible area.
- Supplies a one-cycle frame-start pulse, so game logic updates object positions once per frame.

---
 rtl/vga_sync_gen_pkg.sv | 25 ++
 rtl/vga_tick_div.sv | 37 +++
 rtl/vga_sync_gen.sv | 126 ++++++++++++
 tb/tb_vga_sync_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing definitions for the sync generator and the draw_* object generators.
// Holds the 640x480@60 timing constants, counter widths and the sync polarity helper.
package vga_sync_gen_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int COORD_W = 10;
    localparam int DIV_W   = 4;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DIV_W-1:0]   div_t;

    // Pin level for a sync output given whether its window is active.
    function automatic logic sync_level(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-tick divider: counts 0..CLK_DIV-1 on every iclk, tick on the last count.
module vga_tick_div
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic iclk,
    input  logic ireset,
    output logic otick
);

    localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);

    div_t div_q;
    div_t div_d;

    always_comb begin
        div_d = div_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + div_t'(1);
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // With CLK_DIV=1 the count never leaves 0, so the tick is permanently high.
    assign otick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, sync pulses, video_on and frame-start.
// All flags are registered from next-state counters so they align with opixel_x/opixel_y.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int H_DISPLAY       = VGA_H_DISPLAY,
    parameter int H_FRONT         = VGA_H_FRONT,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BACK          = VGA_H_BACK,
    parameter int V_DISPLAY       = VGA_V_DISPLAY,
    parameter int V_FRONT         = VGA_V_FRONT,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BACK          = VGA_V_BACK,
    parameter int CLK_DIV         = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic               iclk,
    input  logic               ireset,
    output logic [COORD_W-1:0] opixel_x,
    output logic [COORD_W-1:0] opixel_y,
    output logic               ohsync,
    output logic               ovsync,
    output logic               ovideo_on,
    output logic               opixel_tick,
    output logic               oframe_start
);

    localparam int H_TOTAL     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HSYNC_START = H_DISPLAY + H_FRONT;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
    localparam int VSYNC_START = V_DISPLAY + V_FRONT;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(HSYNC_START);
    localparam coord_t HS_END   = coord_t'(HSYNC_END);
    localparam coord_t VS_START = coord_t'(VSYNC_START);
    localparam coord_t VS_END   = coord_t'(VSYNC_END);
    localparam logic   ACT_LOW  = (SYNC_ACTIVE_LOW != 0);

    logic   tick_s;
    logic   h_wrap_s;
    coord_t h_q;
    coord_t h_d;
    coord_t v_q;
    coord_t v_d;
    logic   hsync_q;
    logic   hsync_d;
    logic   vsync_q;
    logic   vsync_d;
    logic   video_on_q;
    logic   video_on_d;
    logic   frame_start_q;
    logic   frame_start_d;

    vga_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .iclk   (iclk),
        .ireset (ireset),
        .otick  (tick_s)
    );

    // Counter advance and flag decode, both taken from the next-state counters.
    always_comb begin
        h_wrap_s      = tick_s && (h_q == H_LAST);
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;

        if (h_wrap_s) begin
            h_d = '0;
        end else if (tick_s) begin
            h_d = h_q + coord_t'(1);
        end else begin
            h_d = h_q;
        end

        if (h_wrap_s) begin
            if (v_q == V_LAST) begin
                v_d           = '0;
                frame_start_d = 1'b1;
            end else begin
                v_d = v_q + coord_t'(1);
            end
        end else begin
            v_d = v_q;
        end

        hsync_d    = sync_level((h_d >= HS_START) && (h_d <= HS_END), ACT_LOW);
        vsync_d    = sync_level((v_d >= VS_START) && (v_d <= VS_END), ACT_LOW);
        video_on_d = (h_d < H_VIS) && (v_d < V_VIS);
    end

    // Counters and output flags; reset parks the syncs at their idle level.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ACT_LOW;
            vsync_q       <= ACT_LOW;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign opixel_x     = h_q;
    assign opixel_y     = v_q;
    assign ohsync       = hsync_q;
    assign ovsync       = vsync_q;
    assign ovideo_on    = video_on_q;
    assign opixel_tick  = tick_s;
    assign oframe_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing (CLK_DIV=2), CLK_DIV=1, and a
// shrunken-timing active-high-sync instance for frame-level behaviour.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic hs_a, vs_a, vid_a, tk_a, fs_a;
    logic hs_b, vs_b, vid_b, tk_b, fs_b;
    logic hs_c, vs_c, vid_c, tk_c, fs_c;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int e       = 0;
    int ticks_a = 0;
    int ticks_b = 0;
    int ticks_c = 0;
    int fs_cnt_a = 0;
    int fs_cnt_c = 0;
    int vs_hi_c  = 0;

    vga_sync_gen u_dut_a (
        .iclk(clk), .ireset(rst_a), .opixel_x(x_a), .opixel_y(y_a),
        .ohsync(hs_a), .ovsync(vs_a), .ovideo_on(vid_a),
        .opixel_tick(tk_a), .oframe_start(fs_a)
    );

    vga_sync_gen #(.CLK_DIV(1)) u_dut_b (
        .iclk(clk), .ireset(rst_b), .opixel_x(x_b), .opixel_y(y_b),
        .ohsync(hs_b), .ovsync(vs_b), .ovideo_on(vid_b),
        .opixel_tick(tk_b), .oframe_start(fs_b)
    );

    // 16 x 10 frame: hsync window x=10..12, vsync window y=7..8, visible 8 x 6.
    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2), .SYNC_ACTIVE_LOW(0)
    ) u_dut_c (
        .iclk(clk), .ireset(rst_c), .opixel_x(x_c), .opixel_y(y_c),
        .ohsync(hs_c), .ovsync(vs_c), .ovideo_on(vid_c),
        .opixel_tick(tk_c), .oframe_start(fs_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to global edge n (counted from the common release), sampling at negedges.
    task automatic adv_to(input int n);
        while (e < n) begin
            @(negedge clk);
            e        = e + 1;
            ticks_a  = ticks_a + int'(tk_a);
            ticks_b  = ticks_b + int'(tk_b);
            ticks_c  = ticks_c + int'(tk_c);
            fs_cnt_a = fs_cnt_a + int'(fs_a);
            fs_cnt_c = fs_cnt_c + int'(fs_c);
            vs_hi_c  = vs_hi_c + int'(vs_c);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_a_x", 32'(x_a), 32'd0);
        chk("rst_a_y", 32'(y_a), 32'd0);
        chk("rst_a_vid", 32'(vid_a), 32'd0);
        chk("rst_a_hs", 32'(hs_a), 32'd1);
        chk("rst_a_vs", 32'(vs_a), 32'd1);
        chk("rst_a_tick", 32'(tk_a), 32'd0);
        chk("rst_a_fs", 32'(fs_a), 32'd0);
        chk("rst_b_tick", 32'(tk_b), 32'd1);
        chk("rst_b_vs", 32'(vs_b), 32'd1);
        chk("rst_c_hs", 32'(hs_c), 32'd0);
        chk("rst_c_vs", 32'(vs_c), 32'd0);
        chk("rst_c_vid", 32'(vid_c), 32'd0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        adv_to(1);
        chk("a_vid_e1", 32'(vid_a), 32'd1);
        chk("a_x_e1", 32'(x_a), 32'd0);
        chk("a_tick_e1", 32'(tk_a), 32'd1);
        chk("b_x_e1", 32'(x_b), 32'd1);
        chk("b_vid_e1", 32'(vid_b), 32'd1);
        chk("c_vid_e1", 32'(vid_c), 32'd1);
        adv_to(2);
        chk("a_x_e2", 32'(x_a), 32'd1);
        chk("a_tick_e2", 32'(tk_a), 32'd0);
        chk("c_x_e2", 32'(x_c), 32'd1);
        adv_to(4);
        chk("a_x_e4", 32'(x_a), 32'd2);

        adv_to(15);  chk("c_vid_x7", 32'(vid_c), 32'd1);
        adv_to(16);  chk("c_vid_x8", 32'(vid_c), 32'd0);
                     chk("c_x_e16", 32'(x_c), 32'd8);
        adv_to(19);  chk("c_hs_x9", 32'(hs_c), 32'd0);
        adv_to(20);  chk("c_hs_x10", 32'(hs_c), 32'd1);
        adv_to(25);  chk("c_hs_x12", 32'(hs_c), 32'd1);
        adv_to(26);  chk("c_hs_x13", 32'(hs_c), 32'd0);
        adv_to(223); chk("c_vs_y6", 32'(vs_c), 32'd0);
                     chk("c_y_e223", 32'(y_c), 32'd6);
        adv_to(224); chk("c_vs_y7", 32'(vs_c), 32'd1);
                     chk("c_vid_y7", 32'(vid_c), 32'd0);
        adv_to(287); chk("c_vs_y8", 32'(vs_c), 32'd1);
        adv_to(288); chk("c_vs_y9", 32'(vs_c), 32'd0);
        adv_to(318); chk("c_fs_pre", 32'(fs_c), 32'd0);
                     chk("c_x_last", 32'(x_c), 32'd15);
                     chk("c_y_last", 32'(y_c), 32'd9);
        adv_to(320); chk("c_fs_wrap", 32'(fs_c), 32'd1);
                     chk("c_x_wrap", 32'(x_c), 32'd0);
                     chk("c_y_wrap", 32'(y_c), 32'd0);
                     chk("c_ticks_frame", 32'(ticks_c), 32'd160);
                     chk("c_fs_count", 32'(fs_cnt_c), 32'd1);
                     chk("c_vs_hi_count", 32'(vs_hi_c), 32'd64);
        adv_to(321); chk("c_fs_one_cycle", 32'(fs_c), 32'd0);

        adv_to(400); chk("c_x_e400", 32'(x_c), 32'd8);
                     chk("c_y_e400", 32'(y_c), 32'd2);
        #2 rst_c = 1'b1;
        #1;
        chk("c_midrst_x", 32'(x_c), 32'd0);
        chk("c_midrst_y", 32'(y_c), 32'd0);
        chk("c_midrst_vid", 32'(vid_c), 32'd0);
        chk("c_midrst_hs", 32'(hs_c), 32'd0);
        chk("c_midrst_tick", 32'(tk_c), 32'd0);
        adv_to(402);
        rst_c = 1'b0;
        adv_to(403); chk("c_rel_vid", 32'(vid_c), 32'd1);
                     chk("c_rel_fs1", 32'(fs_c), 32'd0);
                     chk("c_rel_x1", 32'(x_c), 32'd0);
        adv_to(404); chk("c_rel_x2", 32'(x_c), 32'd1);
                     chk("c_rel_fs2", 32'(fs_c), 32'd0);

        adv_to(655); chk("b_hs_x655", 32'(hs_b), 32'd1);
        adv_to(656); chk("b_hs_x656", 32'(hs_b), 32'd0);
        adv_to(751); chk("b_hs_x751", 32'(hs_b), 32'd0);
        adv_to(752); chk("b_hs_x752", 32'(hs_b), 32'd1);
        adv_to(799); chk("b_x_e799", 32'(x_b), 32'd799);
        adv_to(800); chk("b_x_wrap", 32'(x_b), 32'd0);
                     chk("b_y_wrap", 32'(y_b), 32'd1);
                     chk("b_ticks_line", 32'(ticks_b), 32'd800);
                     chk("b_fs_line", 32'(fs_b), 32'd0);

        adv_to(1278); chk("a_x_639", 32'(x_a), 32'd639);
                      chk("a_vid_639", 32'(vid_a), 32'd1);
        adv_to(1279); chk("a_vid_639b", 32'(vid_a), 32'd1);
        adv_to(1280); chk("a_x_640", 32'(x_a), 32'd640);
                      chk("a_vid_640", 32'(vid_a), 32'd0);
        adv_to(1310); chk("a_hs_x655", 32'(hs_a), 32'd1);
        adv_to(1312); chk("a_hs_x656", 32'(hs_a), 32'd0);
                      chk("a_x_656", 32'(x_a), 32'd656);
        adv_to(1502); chk("a_hs_x751", 32'(hs_a), 32'd0);
        adv_to(1504); chk("a_hs_x752", 32'(hs_a), 32'd1);
        adv_to(1598); chk("a_x_799", 32'(x_a), 32'd799);
                      chk("a_y_799", 32'(y_a), 32'd0);
        adv_to(1600); chk("a_x_wrap", 32'(x_a), 32'd0);
                      chk("a_y_wrap", 32'(y_a), 32'd1);
                      chk("a_vid_line1", 32'(vid_a), 32'd1);
                      chk("a_ticks_line", 32'(ticks_a), 32'd800);
                      chk("a_fs_none", 32'(fs_cnt_a), 32'd0);
                      chk("a_vs_idle", 32'(vs_a), 32'd1);

        adv_to(2200); chk("a_x_300", 32'(x_a), 32'd300);
                      chk("a_y_1", 32'(y_a), 32'd1);
        #2 rst_a = 1'b1;
        #1;
        chk("a_midrst_x", 32'(x_a), 32'd0);
        chk("a_midrst_y", 32'(y_a), 32'd0);
        chk("a_midrst_vid", 32'(vid_a), 32'd0);
        chk("a_midrst_hs", 32'(hs_a), 32'd1);
        chk("a_midrst_tick", 32'(tk_a), 32'd0);
        adv_to(2202);
        rst_a = 1'b0;
        adv_to(2203); chk("a_rel_x1", 32'(x_a), 32'd0);
                      chk("a_rel_vid", 32'(vid_a), 32'd1);
                      chk("a_rel_fs", 32'(fs_a), 32'd0);
        adv_to(2204); chk("a_rel_x2", 32'(x_a), 32'd1);
                      chk("a_rel_fs2", 32'(fs_a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
